serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial adder sequencer. One full-adder cell is shared over WIDTH clock cycles,
//   one bit per cycle from LSB to MSB, so a WIDTH-bit sum costs one cell instead of WIDTH.
//   It sits between the ALU operand registers and the result bus.
//   Handshake: start/busy/done.
// PARAMETERS
//   WIDTH   6   operand and sum width in bits (>= 2)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; sampled only when the block can accept
//   a          in   WIDTH  operand A; captured when start is accepted
//   b          in   WIDTH  operand B; captured when start is accepted
//   carry_in   in   1      initial carry; captured when start is accepted
//   busy       out  1      1 while in RUN
//   done       out  1      one-cycle pulse; sum, carry_out and overflow are valid
//   sum        out  WIDTH  result, a + b + carry_in, modulo 2^WIDTH
//   carry_out  out  1      carry out of the MSB
//   overflow   out  1      two's-complement overflow: carry into MSB XOR carry_out
// BEHAVIOUR
//   - States: IDLE, RUN, DONE. A 3-state FSM with a bit counter of $clog2(WIDTH) bits.
//   - Reset (async, any state):
//     - state = IDLE, counter = 0
//     - operand shift registers cleared; internal carry cleared
//     - busy = 0, done = 0, sum = 0, carry_out = 0, overflow = 0
//   - Accept rule: start is accepted at an edge where the state is IDLE or DONE.
//     - That edge loads a, b and carry_in into internal registers, clears the counter
//       and enters RUN.
//     - start in RUN is ignored. It is neither queued nor does it corrupt the operation.
//   - RUN, per edge (bit i = counter):
//     - full-adder cell computes s = a_sh[0] ^ b_sh[0] ^ c and
//       c' = majority(a_sh[0], b_sh[0], c)
//     - s shifts into sum from the MSB side; a_sh and b_sh shift right; c <= c'
//     - at i = WIDTH-1 the cell's carry input is recorded as c_msb
//   - Counter: increments each RUN edge. At the edge where i = WIDTH-1 is processed:
//     - state goes to DONE
//     - carry_out <= c', overflow <= c_msb ^ c'
//     - the counter wraps to 0
//   - Latency: start is accepted at edge E0 and bits are processed at edges E1..E_WIDTH.
//     done = 1 in the cycle after E_WIDTH, i.e. exactly WIDTH cycles after the accept edge.
//   - DONE lasts one cycle. At the next edge:
//     - start = 1 gives an immediate new RUN (back-to-back, no bubble)
//     - otherwise the state goes to IDLE
//   - Output hold and validity:
//     - sum, carry_out and overflow hold their values in DONE and throughout IDLE,
//       until the next accepted start.
//     - During RUN, sum is partial and undefined for consumers. carry_out and overflow
//       keep their previous values.
//   - busy = (state == RUN); done = (state == DONE). Both are decoded from registered
//     state, with no combinational path from start.
//   - Reset during RUN aborts the operation. No done pulse is produced, and results read 0.
//   - Width rule: the result is exact modulo 2^WIDTH. For example, the all-ones
//     operand + 1 gives sum = 0 and carry_out = 1.
// TESTING (WIDTH = 6)
//   1. a=3, b=1, cin=0, start for 1 cycle -> busy for 6 cycles, then done for 1 cycle;
//      sum=000100, cout=0, ovf=0.
//   2. a=63, b=1, cin=0 -> sum=000000, cout=1, ovf=0.
//      a=31, b=1 -> sum=100000, cout=0, ovf=1.
//   3. a=0, b=0, cin=1 -> sum=000001.
//      Then start held high in DONE with a=5, b=2 -> no idle cycle;
//      the next done shows sum=000111.
//   4. Start a=3, b=1; after 2 cycles pulse start with a=10, b=10 -> second request ignored;
//      result 000100, done exactly 6 cycles after the first accept.
//   5. Start a=20, b=20; assert reset for 1 cycle at cycle 3 -> busy=0, sum=0 immediately;
//      no done pulse; a following start with a=1, b=2 gives sum=000011.
//   6. Exhaustive sweep of all 64x64 operands x cin -> sum, cout and ovf match the
//      behavioural model on every done.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer sharing one full-adder cell over WIDTH cycles, LSB first
module serial_adder_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic c, s, cn, last, accept;
  always_comb begin
    s = a_sh[0] ^ b_sh[0] ^ c;
    cn = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    last = cnt == CW'(WIDTH - 1);
    accept = start && state != RUN;
    next = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // c is the cell's carry input, so on the last bit it is the carry into the MSB
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      c <= 1'b0;
      sum <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      c <= carry_in;
      cnt <= '0;
    end else if (state == RUN) begin
      sum <= {s, sum[WIDTH-1:1]};
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c <= cn;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        carry_out <= cn;
        overflow <= c ^ cn;
      end
    end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
